cache_control: RTL and testbench
================================

Name: cache_control

Overview:
- Control FSM for the 2-way set-associative LC-3b cache datapath (data/tag/valid/dirty arrays per way, one shared LRU array).
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and physical memory (pmem_read/pmem_write/pmem_resp).
- Decodes hit/miss from datapath status, issues per-way array write strobes, and sequences write-back of dirty victims and line allocation.

Parameters:
- NUM_WAYS, 2, ways per set; fixed at 2, since strobe vectors are [1:0].
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mem_read, mem_write  in  1 each  CPU request; held high until mem_resp.
- mem_resp  out  1  CPU request complete; one-cycle pulse.
- is_hit, hit_sel  in  1 each  tag match in some way; matching way index.
- valid0, valid1, dirty0, dirty1  in  1 each  status bits of the indexed set.
- lru  in  1  1 = way1 is LRU, 0 = way0 is LRU.
- pmem_resp  in  1  physical memory transfer done.
- pmem_read, pmem_write  out  1 each  physical memory requests.
- w_data, w_tag, w_valid, w_dirty  out  2 each  per-way write strobes; bit0 = way0, bit1 = way1.
- w_lru  out  1  LRU array write strobe.
- din_valid, din_dirty, din_lru  out  1 each  write data for the valid, dirty and LRU arrays.
- data_src  out  1  data-array input select: 0 = pmem_rdata line, 1 = CPU-merged line.
- pmem_addr_sel  out  1  0 = {CPU tag, index}, 1 = {victim tag, index}.
- victim  out  1  way selected for writeback or fill; drives the pmem_wdata mux.

Behaviour:
- Hit qualification: hit = is_hit & (hit_sel ? valid1 : valid0). A tag match on an invalid way is a miss.
- victim = lru. It is sampled into a register on the IDLE->miss transition and held until the state returns to IDLE.
- mem_read and mem_write both high is illegal; treat it as a write.
- Outputs are Moore/Mealy combinational from state and inputs. Unless stated otherwise, all strobes, requests and mem_resp are 0.
- States:
  - IDLE
  - WRITEBACK
  - ALLOCATE
- IDLE, read hit: in the same cycle, mem_resp=1, w_lru=1, din_lru=~hit_sel. Zero added latency. Stay in IDLE.
- IDLE, write hit, same cycle:
  - data_src=1.
  - w_data[hit_sel]=1.
  - w_dirty[hit_sel]=1 with din_dirty=1.
  - w_lru=1 with din_lru=~hit_sel.
  - mem_resp=1.
  - Stay in IDLE.
- IDLE, miss:
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to ALLOCATE.
  - mem_resp=0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1; hold until pmem_resp.
  - On pmem_resp: w_dirty[victim]=1 with din_dirty=0, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_addr_sel=0; hold until pmem_resp.
  - On pmem_resp, in the same cycle: w_data[victim]=1 with data_src=0; w_tag[victim]=1; w_valid[victim]=1 with din_valid=1; w_dirty[victim]=1 with din_dirty=0. Then go to IDLE.
  - Back in IDLE the access re-evaluates as a hit and completes via the hit path.
- Miss latency, with pmem taking N cycles per transfer:
  - Clean miss: N+2 cycles from request to mem_resp.
  - Dirty miss: 2N+2 cycles.
- pmem_resp while in IDLE is ignored.
- Request dropped during a miss (protocol violation): the in-flight pmem transfer completes, then the FSM returns to IDLE with no mem_resp.
- Reset:
  - rst_n low, including mid-transfer: state=IDLE, victim reg=0, all outputs 0 immediately, no array writes.
  - pmem_read and pmem_write deassert asynchronously.
  - Array contents are not cleared by this block.

Optional Feature:
- Macro: CACHE_CTRL_PERF_CNT_EN.
- Defined: adds output ports hit_count, miss_count, wb_count, each CNT_W wide, each saturating at all-ones and reset to 0 by rst_n.
  - hit_count increments once per hit completion in IDLE, excluding the completion that follows ALLOCATE.
  - miss_count increments on each IDLE->miss transition.
  - wb_count increments on each WRITEBACK exit.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read with valid0=1, is_hit=1, hit_sel=0 -> same-cycle mem_resp=1, w_lru=1, din_lru=1, all other strobes 0.
- Write hit on way1 -> same cycle: w_data=2'b10, w_dirty=2'b10, din_dirty=1, data_src=1, din_lru=0, mem_resp=1.
- Read miss, lru=0, valid0=0, pmem_resp after 3 cycles -> ALLOCATE with pmem_read held 3 cycles; fill cycle w_data=w_tag=w_valid=w_dirty=2'b01, din_valid=1, din_dirty=0; next cycle with is_hit=1 -> mem_resp.
- Write miss, lru=1, valid1=1, dirty1=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp; clear w_dirty=2'b10 with din_dirty=0; then ALLOCATE way1; then write-hit completion sets dirty1.
- Assert rst_n=0 mid-ALLOCATE with pmem_read=1 -> pmem_read drops asynchronously with no clock edge; after release, state is IDLE and no array strobes fire.
- With CACHE_CTRL_PERF_CNT_EN: 3 hits, 1 clean miss, 1 dirty miss -> hit_count=3, miss_count=2, wb_count=1.

Source files
------------

// File: rtl/cache_control_if.sv
// ----------------------------------------------------------------------------
// cache_control_if
//
// Groups every signal between the cache control FSM and the rest of the
// cache: the CPU memory port, the physical memory port, datapath status, and
// the per-way array write strobes.
//
// Handshake semantics (both ports):
//   The requester raises mem_read/mem_write (CPU side) or pmem_read/pmem_write
//   (memory side) and holds it high until the responder pulses mem_resp or
//   pmem_resp for one cycle. The transfer completes in the cycle where the
//   request and the response are both high.
//
// Modports:
//   slave  : the cache controller (drives responses to the CPU, requests to
//            pmem, and the array strobes)
//   master : the environment (CPU, physical memory and datapath status)
// ----------------------------------------------------------------------------
interface cache_control_if;
    // CPU memory port
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    // datapath status for the indexed set
    logic       is_hit;
    logic       hit_sel;
    logic       valid0;
    logic       valid1;
    logic       dirty0;
    logic       dirty1;
    logic       lru;
    // physical memory port
    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    // array write strobes and write data; bit0 = way0, bit1 = way1
    logic [1:0] w_data;
    logic [1:0] w_tag;
    logic [1:0] w_valid;
    logic [1:0] w_dirty;
    logic       w_lru;
    logic       din_valid;
    logic       din_dirty;
    logic       din_lru;
    // datapath mux selects
    logic       data_src;
    logic       pmem_addr_sel;
    logic       victim;

    modport slave (
        input  mem_read, mem_write, is_hit, hit_sel, valid0, valid1,
               dirty0, dirty1, lru, pmem_resp,
        output mem_resp, pmem_read, pmem_write, w_data, w_tag, w_valid,
               w_dirty, w_lru, din_valid, din_dirty, din_lru, data_src,
               pmem_addr_sel, victim
    );

    modport master (
        output mem_read, mem_write, is_hit, hit_sel, valid0, valid1,
               dirty0, dirty1, lru, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, w_data, w_tag, w_valid,
               w_dirty, w_lru, din_valid, din_dirty, din_lru, data_src,
               pmem_addr_sel, victim
    );
endinterface

// File: rtl/cache_control.sv
// ----------------------------------------------------------------------------
// cache_control
//
// Control FSM for the 2-way set-associative LC-3b cache. Hits complete in the
// request cycle; misses write back a dirty victim (WRITEBACK), then fill the
// victim way from physical memory (ALLOCATE), then return to IDLE where the
// access re-evaluates as a hit.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset; all outputs forced to 0 while low
//   bus        cache_control_if.slave (CPU port, pmem port, status, strobes)
//   dbg_state  current FSM state (0 = IDLE, 1 = WRITEBACK, 2 = ALLOCATE)
//
// Optional feature, macro CACHE_CTRL_PERF_CNT_EN:
//   adds parameter CNT_W and saturating outputs hit_count, miss_count and
//   wb_count (CNT_W bits each). Without the macro they do not exist.
// ----------------------------------------------------------------------------
module cache_control #(
    parameter int NUM_WAYS = 2
`ifdef CACHE_CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_control_if.slave       bus,
`ifdef CACHE_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count,
    output logic [CNT_W-1:0]     wb_count,
`endif
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                victim_q;
    logic                req;
    logic                hit;
    logic                victim_dirty;
    logic                cur_victim;
    logic [NUM_WAYS-1:0] hit_oh;
    logic [NUM_WAYS-1:0] vic_oh;

    // Read and write together is treated as a write, so a request is simply
    // either strobe and the write path keys off mem_write alone.
    assign req          = bus.mem_read | bus.mem_write;
    // A tag match on an invalid way must not count as a hit.
    assign hit          = bus.is_hit & (bus.hit_sel ? bus.valid1 : bus.valid0);
    assign victim_dirty = bus.lru ? (bus.valid1 & bus.dirty1)
                                  : (bus.valid0 & bus.dirty0);
    // In IDLE the victim follows lru; during a miss it is the captured way.
    assign cur_victim   = (state == IDLE) ? bus.lru : victim_q;
    assign hit_oh       = NUM_WAYS'(1) << bus.hit_sel;
    assign vic_oh       = NUM_WAYS'(1) << victim_q;
    assign dbg_state    = state;

    // State register and victim capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req && !hit) begin
                victim_q <= bus.lru;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                // A request dropped mid-miss ends after the current transfer.
                if (bus.pmem_resp) begin
                    state_nxt = req ? ALLOCATE : IDLE;
                end
            end
            ALLOCATE: begin
                if (bus.pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; everything is gated by rst_n so requests and strobes
    // drop asynchronously with reset.
    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.w_data        = '0;
        bus.w_tag         = '0;
        bus.w_valid       = '0;
        bus.w_dirty       = '0;
        bus.w_lru         = 1'b0;
        bus.din_valid     = 1'b0;
        bus.din_dirty     = 1'b0;
        bus.din_lru       = 1'b0;
        bus.data_src      = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.victim        = rst_n & cur_victim;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        bus.mem_resp = 1'b1;
                        bus.w_lru    = 1'b1;
                        bus.din_lru  = ~bus.hit_sel;
                        if (bus.mem_write) begin
                            bus.data_src  = 1'b1;
                            bus.w_data    = hit_oh;
                            bus.w_dirty   = hit_oh;
                            bus.din_dirty = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.w_dirty = vic_oh;
                    end
                end
                ALLOCATE: begin
                    bus.pmem_read = 1'b1;
                    if (bus.pmem_resp) begin
                        bus.w_data    = vic_oh;
                        bus.w_tag     = vic_oh;
                        bus.w_valid   = vic_oh;
                        bus.w_dirty   = vic_oh;
                        bus.din_valid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    // after_fill marks the cycle right after a fill, whose hit completes the
    // original miss and so is not a new hit.
    logic after_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            after_fill <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            after_fill <= (state == ALLOCATE) && bus.pmem_resp && req;
            if (state == IDLE && req && hit && !after_fill && hit_count != '1) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (state == IDLE && req && !hit && miss_count != '1) begin
                miss_count <= miss_count + CNT_W'(1);
            end
            if (state == WRITEBACK && bus.pmem_resp && wb_count != '1) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_control.sv
// ----------------------------------------------------------------------------
// tb_cache_control
//
// Scripted-datapath bench for cache_control. Each transaction is described
// by its set status and pmem latency; a reference model derives the expected
// output vector for every cycle from the hit/miss rules and the latency, and
// pushes it into exp_q. A monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_control;
    localparam int W = 18;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    cache_control_if bus();

`ifdef CACHE_CTRL_PERF_CNT_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    cache_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
`ifdef CACHE_CTRL_PERF_CNT_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
        .wb_count  (wb_count),
`endif
        .dbg_state (dbg_state)
    );

    // Output vector layout (LSB first): victim, pmem_addr_sel, data_src,
    // din_lru, din_dirty, din_valid, w_lru, w_dirty[8:7], w_valid[10:9],
    // w_tag[12:11], w_data[14:13], pmem_write, pmem_read, mem_resp.
    logic [W-1:0] act;
    assign act = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.w_data,
                  bus.w_tag, bus.w_valid, bus.w_dirty, bus.w_lru,
                  bus.din_valid, bus.din_dirty, bus.din_lru, bus.data_src,
                  bus.pmem_addr_sel, bus.victim};

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    bit           vcare_q[$];
    int           id_q[$];
    int           total = 0;
    int           bad   = 0;
    int           txn_id = 0;
    int           m_hits = 0, m_miss = 0, m_wb = 0;

    function automatic logic [W-1:0] mk(bit resp, bit prd, bit pwr,
                                        logic [1:0] wd, logic [1:0] wt,
                                        logic [1:0] wv, logic [1:0] wdy,
                                        bit wl, bit dv, bit dd, bit dl,
                                        bit ds, bit as, bit vic);
        return {resp, prd, pwr, wd, wt, wv, wdy, wl, dv, dd, dl, ds, as, vic};
    endfunction

    function automatic logic [1:0] oh(bit way);
        return way ? 2'b10 : 2'b01;
    endfunction

    // Write-data and select fields only matter when their strobe is active.
    function automatic logic [W-1:0] care_mask(logic [W-1:0] e, bit vcare);
        logic [W-1:0] m;
        m    = '1;
        m[5] = |e[10:9];
        m[4] = |e[8:7];
        m[3] = e[6];
        m[2] = |e[14:13];
        m[1] = e[16] | e[15];
        m[0] = vcare;
        return m;
    endfunction

    function automatic logic [W-1:0] hit_vec(bit wr, bit hs);
        return mk(1'b1, 1'b0, 1'b0, wr ? oh(hs) : 2'b00, 2'b00, 2'b00,
                  wr ? oh(hs) : 2'b00, 1'b1, 1'b0, wr, ~hs, wr, 1'b0, 1'b0);
    endfunction

    task automatic push(input logic [W-1:0] e, input bit vcare);
        exp_q.push_back(e);
        vcare_q.push_back(vcare);
        id_q.push_back(txn_id);
    endtask

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, m;
        bit           vc;
        int           id;
        if (rst_n && (exp_q.size() > 0 || (|act[17:6]))) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output t=%0t got=%b", $time, act);
            end else begin
                e  = exp_q.pop_front();
                vc = vcare_q.pop_front();
                id = id_q.pop_front();
                m  = care_mask(e, vc);
                if ((act & m) !== (e & m)) begin
                    bad++;
                    $display("FAIL txn%0d_outputs t=%0t got=%b exp=%b care=%b",
                             id, $time, act, e, m);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver tasks start and end at posedge + 1.
    task automatic idle_cycles(input int c);
        for (int i = 0; i < c; i++) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.is_hit    = 1'($urandom_range(0, 1));
            bus.hit_sel   = 1'($urandom_range(0, 1));
            bus.valid0    = 1'($urandom_range(0, 1));
            bus.valid1    = 1'($urandom_range(0, 1));
            bus.dirty0    = 1'($urandom_range(0, 1));
            bus.dirty1    = 1'($urandom_range(0, 1));
            bus.lru       = 1'($urandom_range(0, 1));
            bus.pmem_resp = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic set_req(input bit on, input bit wr);
        bus.mem_write = on & wr;
        bus.mem_read  = on & (wr ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic run_txn(input bit wr, input bit drop, input int n,
                           input bit v0, input bit v1, input bit d0,
                           input bit d1, input bit lr, input bit ih,
                           input bit hs);
        bit vl[2];
        bit dt[2];
        bit hit, dcase, v;
        int wb_end, al_end, len;
        vl[0] = v0; vl[1] = v1; dt[0] = d0; dt[1] = d1;
        txn_id++;
        hit    = ih && vl[hs];
        v      = lr;
        dcase  = !hit && vl[v] && dt[v];
        wb_end = dcase ? n : 0;
        al_end = wb_end + n;
        len    = hit ? 1 : (drop ? n + 1 : al_end + 2);
        if (hit) m_hits++; else m_miss++;
        if (dcase) m_wb++;
        for (int k = 0; k < len; k++) begin
            if (k == 0) begin
                set_req(1'b1, wr);
                bus.valid0 = vl[0]; bus.valid1 = vl[1];
                bus.dirty0 = dt[0]; bus.dirty1 = dt[1];
                bus.lru = lr; bus.is_hit = ih; bus.hit_sel = hs;
                bus.pmem_resp = 1'($urandom_range(0, 1));
                if (hit) push(hit_vec(wr, hs), 1'b0);
                else push(mk(0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0,0,v), 1'b1);
            end else if (k <= wb_end) begin
                if (drop) set_req(1'b0, wr);
                bus.lru       = 1'($urandom_range(0, 1));
                bus.pmem_resp = (k == wb_end);
                push(mk(0, 0, 1, 2'b00, 2'b00, 2'b00,
                        (k == wb_end) ? oh(v) : 2'b00, 0, 0, 0, 0, 0, 1, v), 1'b1);
            end else if (k <= al_end) begin
                if (drop) set_req(1'b0, wr);
                bus.dirty0    = (v == 1'b0) ? 1'b0 : dt[0];
                bus.dirty1    = (v == 1'b1) ? 1'b0 : dt[1];
                bus.lru       = 1'($urandom_range(0, 1));
                bus.pmem_resp = (k == al_end);
                if (k == al_end)
                    push(mk(0, 1, 0, oh(v), oh(v), oh(v), oh(v), 0, 1, 0, 0, 0, 0, v), 1'b1);
                else
                    push(mk(0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, v), 1'b1);
            end else begin
                // The fill has landed: the victim way now matches and is clean.
                if (v) begin bus.valid1 = 1'b1; bus.dirty1 = 1'b0; end
                else   begin bus.valid0 = 1'b1; bus.dirty0 = 1'b0; end
                bus.is_hit    = 1'b1;
                bus.hit_sel   = v;
                bus.lru       = 1'($urandom_range(0, 1));
                bus.pmem_resp = 1'($urandom_range(0, 1));
                push(hit_vec(wr, v), 1'b0);
            end
            @(posedge clk); #1;
        end
        set_req(1'b0, wr);
        bus.pmem_resp = 1'b0;
    endtask

    task automatic rand_txn();
        bit vl[2];
        bit dt[2];
        bit lr, ih, hs, wr, drop;
        int kind, n;
        kind  = $urandom_range(0, 2);
        lr    = 1'($urandom_range(0, 1));
        wr    = 1'($urandom_range(0, 1));
        drop  = ($urandom_range(0, 7) == 0);
        n     = $urandom_range(1, 4);
        for (int i = 0; i < 2; i++) begin
            vl[i] = 1'($urandom_range(0, 1));
            dt[i] = 1'($urandom_range(0, 1));
        end
        if (kind == 0) begin
            hs = 1'($urandom_range(0, 1)); ih = 1'b1; vl[hs] = 1'b1; drop = 1'b0;
        end else begin
            if (kind == 1) begin
                if ($urandom_range(0, 1) == 0) vl[lr] = 1'b0; else dt[lr] = 1'b0;
            end else begin
                vl[lr] = 1'b1; dt[lr] = 1'b1;
            end
            // Miss: either no tag match, or a match on an invalid way.
            if (!vl[0] && $urandom_range(0, 1) == 1) begin ih = 1'b1; hs = 1'b0; end
            else if (!vl[1] && $urandom_range(0, 1) == 1) begin ih = 1'b1; hs = 1'b1; end
            else begin ih = 1'b0; hs = 1'($urandom_range(0, 1)); end
        end
        run_txn(wr, drop, n, vl[0], vl[1], dt[0], dt[1], lr, ih, hs);
        idle_cycles(drop ? 2 : $urandom_range(0, 2));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.is_hit = 1'b1; bus.hit_sel = 1'b0;
        bus.valid0 = 1'b1; bus.valid1 = 1'b1;
        bus.dirty0 = 1'b1; bus.dirty1 = 1'b1;
        bus.lru = 1'b1; bus.pmem_resp = 1'b1;
        #2;
        chk("reset_outputs", act, '0);
        chk("reset_state", W'(dbg_state), '0);
        @(posedge clk); #1;
        chk("reset_outputs_clocked", act, '0);
        set_req(1'b0, 1'b0);
        bus.pmem_resp = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);

        // Reset in the middle of ALLOCATE.
        txn_id++;
        set_req(1'b1, 1'b0);
        bus.valid0 = 1'b0; bus.lru = 1'b0; bus.is_hit = 1'b0; bus.pmem_resp = 1'b0;
        push(mk(0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0,0,0), 1'b1);
        @(posedge clk); #1;
        push(mk(0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0,0,0), 1'b1);
        @(posedge clk); #1;
        chk("alloc_pmem_read_before_reset", W'(bus.pmem_read), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", act, '0);
        chk("async_reset_state", W'(dbg_state), '0);
        bus.pmem_resp = 1'b1;
        @(posedge clk); #1;
        chk("reset_no_strobes", act, '0);
        set_req(1'b0, 1'b0);
        bus.pmem_resp = 1'b0;
        rst_n = 1'b1;
        idle_cycles(2);
`ifdef CACHE_CTRL_PERF_CNT_EN
        chk("hit_count_reset", W'(hit_count), '0);
        chk("miss_count_reset", W'(miss_count), '0);
        chk("wb_count_reset", W'(wb_count), '0);
`endif
        m_hits = 0; m_miss = 0; m_wb = 0;

        // Directed transactions.
        run_txn(1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 1, 0);   // read hit way0
        run_txn(1'b1, 1'b0, 1, 1, 1, 0, 0, 0, 1, 1);   // write hit way1
        idle_cycles(1);
        run_txn(1'b0, 1'b0, 3, 0, 1, 0, 0, 0, 0, 0);   // clean read miss, way0
        idle_cycles(1);
        run_txn(1'b1, 1'b0, 2, 1, 1, 0, 1, 1, 0, 0);   // dirty write miss, way1
        idle_cycles(1);
        run_txn(1'b0, 1'b0, 2, 1, 0, 0, 0, 1, 1, 1);   // tag match on invalid way1
        idle_cycles(1);
        run_txn(1'b0, 1'b1, 3, 0, 0, 0, 0, 0, 0, 0);   // dropped clean miss
        idle_cycles(2);
        run_txn(1'b1, 1'b1, 2, 1, 1, 1, 0, 0, 0, 0);   // dropped dirty miss
        idle_cycles(2);

        for (int i = 0; i < 60; i++) rand_txn();

        idle_cycles(3);
        chk("queue_drained", W'(exp_q.size()), '0);
`ifdef CACHE_CTRL_PERF_CNT_EN
        chk("hit_count", W'(hit_count), W'(m_hits));
        chk("miss_count", W'(miss_count), W'(m_miss));
        chk("wb_count", W'(wb_count), W'(m_wb));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
